// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle RV32I control sequencer stepping IDLE/DECODE/EXEC/MEM/WB.
// Optional feature: define CTRL_SEQ_TRAP_EN to add a TRAP state and a trap output for illegal opcodes.
module ctrl_seq #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned RET_CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    input  logic [31:0]          instr,
    output logic                 instr_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    input  logic                 mem_ack,
    output logic                 alu_sub,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic                 pc_offset_en,
    output logic                 mem_err,
`ifdef CTRL_SEQ_TRAP_EN
    output logic                 trap,
`endif
    output logic [RET_CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StExec,
        StMem,
        StWb
`ifdef CTRL_SEQ_TRAP_EN
        , StTrap
`endif
    } state_e;

    state_e            state;
    logic [31:0]       ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic       is_load;
    logic       is_store;
    logic       is_mem_op;
    logic       is_jal;
    logic       writes_rd;
    logic       dec_alu_sub;
    logic [1:0] dec_wb_sel;
    logic       wait_last;
    logic       timeout;
    logic       go_wb;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign rd        = ir[11:7];
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_mem_op = is_load || is_store;
    assign is_jal    = (opcode == OpJal);
    assign unused_ir = ^ir[24:15];

    always_comb begin
        writes_rd  = 1'b0;
        dec_wb_sel = 2'b00;
        case (opcode)
            OpLui: begin
                writes_rd  = 1'b1;
                dec_wb_sel = 2'b11;
            end
            OpJal, OpJalr: begin
                writes_rd  = 1'b1;
                dec_wb_sel = 2'b10;
            end
            OpLoad: begin
                writes_rd  = 1'b1;
                dec_wb_sel = 2'b01;
            end
            OpAuipc, OpOpImm, OpOp: begin
                writes_rd  = 1'b1;
            end
            default: begin
                writes_rd  = 1'b0;
            end
        endcase
        dec_alu_sub = (opcode == OpOp) && (ir[14:12] == 3'b000) && (ir[31:25] == 7'b0100000);
    end

`ifdef CTRL_SEQ_TRAP_EN
    logic is_legal;

    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
            OpStore, OpOpImm, OpOp, OpFence, OpSystem: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end
`endif

    // An ack in the last allowed wait cycle takes priority over the timeout.
    assign wait_last = (wait_cnt == WAIT_W'(MEM_WAIT_MAX - 1));
    assign timeout   = (state == StMem) && !mem_ack && wait_last;
    assign go_wb     = ((state == StExec) && !is_mem_op) ||
                       ((state == StMem) && (mem_ack || wait_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            ir           <= '0;
            wait_cnt     <= '0;
            timed_out    <= 1'b0;
            instr_ready  <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            alu_sub      <= 1'b0;
            reg_we       <= 1'b0;
            wb_sel       <= 2'b00;
            pc_we        <= 1'b0;
            pc_offset_en <= 1'b0;
            mem_err      <= 1'b0;
            retired      <= '0;
`ifdef CTRL_SEQ_TRAP_EN
            trap         <= 1'b0;
`endif
        end else begin
            reg_we       <= 1'b0;
            pc_we        <= 1'b0;
            pc_offset_en <= 1'b0;
            mem_err      <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (instr_valid) begin
                        ir          <= instr;
                        instr_ready <= 1'b0;
                        state       <= StDecode;
                    end
                end
                StDecode: begin
                    alu_sub <= dec_alu_sub;
                    wb_sel  <= dec_wb_sel;
                    state   <= StExec;
`ifdef CTRL_SEQ_TRAP_EN
                    // Illegal opcodes park in TRAP with every strobe low.
                    if (!is_legal) begin
                        alu_sub <= 1'b0;
                        wb_sel  <= 2'b00;
                        trap    <= 1'b1;
                        state   <= StTrap;
                    end
`endif
                end
                StExec: begin
                    if (is_mem_op) begin
                        mem_req  <= 1'b1;
                        mem_we   <= is_store;
                        wait_cnt <= '0;
                        state    <= StMem;
                    end else begin
                        state    <= StWb;
                    end
                end
                StMem: begin
                    if (mem_ack || wait_last) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= StWb;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                StWb: begin
                    if (!timed_out) begin
                        retired <= retired + 1'b1;
                    end
                    timed_out   <= 1'b0;
                    alu_sub     <= 1'b0;
                    wb_sel      <= 2'b00;
                    instr_ready <= 1'b1;
                    state       <= StIdle;
                end
`ifdef CTRL_SEQ_TRAP_EN
                StTrap: begin
                    state <= StTrap;
                end
`endif
                default: begin
                    state <= StIdle;
                end
            endcase

            if (go_wb) begin
                reg_we       <= writes_rd && (rd != 5'd0) && !(is_load && timeout);
                pc_we        <= 1'b1;
                pc_offset_en <= is_jal;
                mem_err      <= timeout;
                timed_out    <= timeout;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
`timescale 1ns/1ps
// tb_ctrl_seq: directed vector table, hand-written corner sequences and a randomized run
// checked against a transaction-level model of ctrl_seq.
module tb_ctrl_seq;

    localparam int unsigned MAXW = 15;
    localparam int unsigned RETW = 4;  // narrow counter so the random run wraps it

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef struct {
        logic [31:0] instr;
        int          ack_d;   // MEM cycle index carrying mem_ack, -1 for none
        bit          reg_we;
        logic [1:0]  wb_sel;
        bit          alu_sub;
        bit          pc_off;
        bit          is_mem;
        bit          store;
        bit          err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_ack;
    logic             alu_sub;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             pc_we;
    logic             pc_offset_en;
    logic             mem_err;
    logic             trap;
    logic [RETW-1:0]  retired;

    int          n_vec = 0;
    int          n_miss = 0;
    int          exp_ret = 0;
    logic [31:0] cur_instr = '0;

    always #5 clk = ~clk;

    ctrl_seq #(
        .MEM_WAIT_MAX(MAXW),
        .RET_CNT_W   (RETW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .alu_sub     (alu_sub),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .pc_we       (pc_we),
        .pc_offset_en(pc_offset_en),
        .mem_err     (mem_err),
`ifdef CTRL_SEQ_TRAP_EN
        .trap        (trap),
`endif
        .retired     (retired)
    );

`ifndef CTRL_SEQ_TRAP_EN
    assign trap = 1'b0;
`endif

    function automatic logic [10:0] pack(input bit rdy, input bit mq, input bit mw, input bit as,
                                         input bit rw, input logic [1:0] ws, input bit pw,
                                         input bit po, input bit me, input bit tr);
        return {rdy, mq, mw, as, rw, ws, pw, po, me, tr};
    endfunction

    function automatic logic [10:0] idle_outs();
        return pack(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [10:0] want);
        logic [10:0] got;
        got = {instr_ready, mem_req, mem_we, alu_sub, reg_we, wb_sel, pc_we, pc_offset_en,
               mem_err, trap};
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s instr=%h: got rdy,mreq,mwe,sub,rwe,wsel,pcwe,pcoff,merr,trap=%b want %b",
                     nm, cur_instr, got, want);
        end
    endtask

    task automatic check_ret(input string nm);
        n_vec++;
        if (retired !== RETW'(exp_ret)) begin
            n_miss++;
            $display("FAIL %s: retired got %0d want %0d", nm, retired, exp_ret);
        end
    endtask

    // Transaction-level model: what each instruction must do, from its opcode fields alone.
    function automatic vec_t model(input logic [31:0] ins, input int ack_d);
        vec_t       m;
        logic [6:0] op;
        op        = ins[6:0];
        m.instr   = ins;
        m.ack_d   = ack_d;
        m.is_mem  = (op == OpLoad) || (op == OpStore);
        m.store   = (op == OpStore);
        m.err     = m.is_mem && !(ack_d >= 0 && ack_d <= int'(MAXW) - 1);
        m.reg_we  = (op inside {OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpOpImm, OpOp}) &&
                    (ins[11:7] != 5'd0) && !((op == OpLoad) && m.err);
        m.wb_sel  = (op == OpLui) ? 2'b11 :
                    ((op == OpJal) || (op == OpJalr)) ? 2'b10 :
                    (op == OpLoad) ? 2'b01 : 2'b00;
        m.alu_sub = (op == OpOp) && (ins[14:12] == 3'b000) && (ins[31:25] == 7'b0100000);
        m.pc_off  = (op == OpJal);
        return m;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [13];
        logic [31:0] w;
        int          n;
        ops = '{OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad, OpStore, OpOpImm, OpOp,
                OpFence, OpSystem, 7'b0001011, 7'b0110001};
        n = 11;
`ifndef CTRL_SEQ_TRAP_EN
        n = 13;
`endif
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, n - 1)];
        if (w[6:0] == OpOp && $urandom_range(0, 1) == 1) begin
            w[31:25] = 7'b0100000;
            w[14:12] = 3'b000;
        end
        if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    // Drives one instruction from an IDLE cycle and checks every cycle until the next IDLE.
    task automatic run_instr(input vec_t v);
        int nmem;
        cur_instr = v.instr;
        check("idle", idle_outs());
        check_ret("idle_retired");
        instr_valid = 1'b1;
        instr       = v.instr;
        mem_ack     = 1'($urandom_range(0, 1));
        step();
        instr_valid = 1'($urandom_range(0, 1));
        instr       = $urandom;
        mem_ack     = 1'($urandom_range(0, 1));
        check("decode", pack(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step();
        check("exec", pack(0, 0, 0, v.alu_sub, 0, v.wb_sel, 0, 0, 0, 0));
        instr_valid = 1'($urandom_range(0, 1));
        mem_ack     = 1'($urandom_range(0, 1));
        if (v.is_mem) begin
            nmem = (v.ack_d >= 0 && v.ack_d < int'(MAXW)) ? v.ack_d + 1 : int'(MAXW);
            for (int k = 0; k < nmem; k++) begin
                step();
                check("mem", pack(0, 1, v.store, v.alu_sub, 0, v.wb_sel, 0, 0, 0, 0));
                mem_ack     = (k == v.ack_d);
                instr_valid = 1'($urandom_range(0, 1));
            end
        end
        step();
        check("wb", pack(0, 0, 0, v.alu_sub, v.reg_we, v.wb_sel, 1, v.pc_off, v.err, 0));
        mem_ack     = 1'($urandom_range(0, 1));
        instr_valid = 1'($urandom_range(0, 1));
        step();
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        if (!v.err) exp_ret = (exp_ret + 1) % (1 << RETW);
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] ins;
        int ack;

        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        mem_ack = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("reset", idle_outs());
        check_ret("reset_retired");

        //             instr         ack rwe wsel  sub off mem st err
        tbl.push_back('{32'h002081B3,  0, 1, 2'b00, 0, 0, 0, 0, 0});  // ADD x3
        tbl.push_back('{32'h407302B3,  0, 1, 2'b00, 1, 0, 0, 0, 0});  // SUB x5,x6,x7
        tbl.push_back('{32'h407312B3,  0, 1, 2'b00, 0, 0, 0, 0, 0});  // funct7=0100000, funct3=001
        tbl.push_back('{32'h0000A103,  4, 1, 2'b01, 0, 0, 1, 0, 0});  // LW x2, ack after 4
        tbl.push_back('{32'h0020A023, -1, 0, 2'b00, 0, 0, 1, 1, 1});  // SW, timeout
        tbl.push_back('{32'h008000EF,  0, 1, 2'b10, 0, 1, 0, 0, 0});  // JAL x1
        tbl.push_back('{32'h00100013,  0, 0, 2'b00, 0, 0, 0, 0, 0});  // ADDI x0
        tbl.push_back('{32'h123452B7,  0, 1, 2'b11, 0, 0, 0, 0, 0});  // LUI x5
        tbl.push_back('{32'h000080E7,  0, 1, 2'b10, 0, 0, 0, 0, 0});  // JALR x1
        tbl.push_back('{32'h0000A103, -1, 0, 2'b01, 0, 0, 1, 0, 1});  // LW, timeout
        tbl.push_back('{32'h0000A103, 14, 1, 2'b01, 0, 0, 1, 0, 0});  // LW, ack in final cycle
        tbl.push_back('{32'h0000A103,  0, 1, 2'b01, 0, 0, 1, 0, 0});  // LW, immediate ack
        tbl.push_back('{32'h00208063,  0, 0, 2'b00, 0, 0, 0, 0, 0});  // BEQ
        tbl.push_back('{32'h00000397,  0, 1, 2'b00, 0, 0, 0, 0, 0});  // AUIPC x7
        tbl.push_back('{32'h0000000F,  0, 0, 2'b00, 0, 0, 0, 0, 0});  // FENCE
        tbl.push_back('{32'h00000073,  0, 0, 2'b00, 0, 0, 0, 0, 0});  // ECALL
        tbl.push_back('{32'h0020A023,  2, 0, 2'b00, 0, 0, 1, 1, 0});  // SW, ack after 2
`ifndef CTRL_SEQ_TRAP_EN
        tbl.push_back('{32'h0000008B,  0, 0, 2'b00, 0, 0, 0, 0, 0});  // illegal -> no-op
`endif
        foreach (tbl[i]) run_instr(tbl[i]);
        run_instr(tbl[0]);

        // Reset while waiting in MEM.
        cur_instr   = 32'h0000A103;
        check_ret("pre_rst_retired");
        instr_valid = 1'b1;
        instr       = cur_instr;
        mem_ack     = 1'b0;
        step();
        instr_valid = 1'b0;
        step();
        step();
        check("rst_mem_in", pack(0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ret = 0;
        check("rst_mem_out", idle_outs());
        check_ret("rst_mem_retired");
        step();
        check("rst_mem_idle", idle_outs());

`ifdef CTRL_SEQ_TRAP_EN
        cur_instr   = 32'h00000000;
        instr_valid = 1'b1;
        instr       = cur_instr;
        step();
        instr_valid = 1'b0;
        check("trap_decode", pack(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        step();
        for (int k = 0; k < 6; k++) begin
            check("trap_hold", pack(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
            instr_valid = 1'b1;
            instr       = 32'h002081B3;
            mem_ack     = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b1;
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        step();
        rst = 1'b0;
        exp_ret = 0;
        check("trap_rst", idle_outs());
        check_ret("trap_rst_retired");
`endif

        for (int i = 0; i < 80; i++) begin
            ins = rand_instr();
            ack = int'($urandom_range(0, 17)) - 1;
            run_instr(model(ins, ack));
        end
        check("final_idle", idle_outs());
        check_ret("final_retired");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
